// File: rtl/count_cmd_sched_pkg.sv
`default_nettype none
//============================================================================
// count_cmd_sched_pkg : shared key-FSM encodings and BCD constants
// Rev 1.0
//============================================================================
package count_cmd_sched_pkg;

    typedef enum logic [0:0] {
        K_IDLE = 1'b0,
        K_HELD = 1'b1
    } key_state_t;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] DEF_CLR_KEY = 4'hF;

endpackage
`default_nettype wire

// File: rtl/count_cmd_sched_if.sv
`default_nettype none
//============================================================================
// count_cmd_sched_if : request inputs and digit/status outputs of the scheduler
// Rev 1.0
//============================================================================
interface count_cmd_sched_if;

    logic       add_pulse;
    logic       sub_pulse;
    logic       pressed;
    logic [3:0] key;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] in3;
    logic       busy;
    logic       drop;

    modport master (
        output add_pulse, sub_pulse, pressed, key,
        input  in0, in1, in2, in3, busy, drop
    );

    modport slave (
        input  add_pulse, sub_pulse, pressed, key,
        output in0, in1, in2, in3, busy, drop
    );

endinterface
`default_nettype wire

// File: rtl/count_cmd_sched_bcd4_step.sv
`default_nettype none
//============================================================================
// count_cmd_sched_bcd4_step : combinational 4-digit BCD +1/-1 with wrap flag
// Rev 1.0
//============================================================================
module count_cmd_sched_bcd4_step
    import count_cmd_sched_pkg::*;
(
    input  wire logic [15:0] value,
    input  wire logic        up,
    output logic      [15:0] next,
    output logic             wrap
);

    // w_carry[i] high means digit i must change (carry/borrow into it)
    logic [4:0] w_carry;
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        logic [3:0] w_digit;
        logic       w_at_edge;

        assign w_digit   = value[4*i +: 4];
        assign w_at_edge = up ? (w_digit == BCD_MAX) : (w_digit == 4'd0);

        assign next[4*i +: 4] = !w_carry[i] ? w_digit :
                                w_at_edge   ? (up ? 4'd0 : BCD_MAX) :
                                (up ? w_digit + 4'd1 : w_digit - 4'd1);
        assign w_carry[i+1]   = w_carry[i] & w_at_edge;
    end

    assign wrap = w_carry[4];

endmodule
`default_nettype wire

// File: rtl/count_cmd_sched.sv
`default_nettype none
//============================================================================
// count_cmd_sched : one-op-per-clock scheduler for a 4-digit BCD count register
// Optional: COUNT_SATURATE_EN holds the count at 9999/0000 instead of wrapping.
// Rev 1.0
//============================================================================
module count_cmd_sched
    import count_cmd_sched_pkg::*;
#(
    parameter logic [3:0] CLR_KEY   = DEF_CLR_KEY,
    parameter logic [3:0] MAX_DIGIT = BCD_MAX
)
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    count_cmd_sched_if.slave  bus
);

`ifdef COUNT_SATURATE_EN
    localparam logic c_saturate = 1'b1;
`else
    localparam logic c_saturate = 1'b0;
`endif

    key_state_t  r_key_state;
    logic [3:0]  r_key;
    logic [15:0] r_value;
    logic        r_pend_key;
    logic        r_pend_add;
    logic        r_pend_sub;
    logic        r_busy;
    logic        r_drop;

    logic        w_key_req;
    logic [3:0]  w_key_code;
    logic        w_key_present;
    logic        w_add_present;
    logic        w_sub_present;
    logic        w_grant_key;
    logic        w_grant_add;
    logic        w_grant_sub;
    logic        w_cancel;
    logic        w_next_pend_key;
    logic        w_next_pend_add;
    logic        w_next_pend_sub;
    logic        w_drop;
    logic [15:0] w_step;
    logic        w_wrap;
    logic [15:0] w_next_value;

    assign w_key_req     = (r_key_state == K_IDLE) && bus.pressed;
    assign w_key_code    = w_key_req ? bus.key : r_key;
    assign w_key_present = r_pend_key | w_key_req;
    assign w_add_present = r_pend_add | bus.add_pulse;
    assign w_sub_present = r_pend_sub | bus.sub_pulse;

    assign w_grant_key = w_key_present;
    assign w_cancel    = !w_key_present &  w_add_present &  w_sub_present;
    assign w_grant_add = !w_key_present &  w_add_present & !w_sub_present;
    assign w_grant_sub = !w_key_present & !w_add_present &  w_sub_present;

    assign w_next_pend_key = w_key_present & !w_grant_key;
    assign w_next_pend_add = w_add_present & !(w_grant_add | w_cancel);
    assign w_next_pend_sub = w_sub_present & !(w_grant_sub | w_cancel);

    // A request landing on an occupied slot is lost; the occupant is served normally
    assign w_drop = (bus.add_pulse & r_pend_add) |
                    (bus.sub_pulse & r_pend_sub) |
                    (w_key_req     & r_pend_key);

    count_cmd_sched_bcd4_step u_step (
        .value (r_value),
        .up    (w_grant_add),
        .next  (w_step),
        .wrap  (w_wrap)
    );

    always_comb begin
        w_next_value = r_value;
        if (w_grant_key) begin
            if (w_key_code == CLR_KEY)
                w_next_value = 16'h0000;
            else if (w_key_code <= MAX_DIGIT)
                w_next_value = {r_value[11:0], w_key_code};
        end else if ((w_grant_add | w_grant_sub) && !(c_saturate && w_wrap)) begin
            w_next_value = w_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_state <= K_IDLE;
            r_key       <= 4'd0;
            r_value     <= 16'h0000;
            r_pend_key  <= 1'b0;
            r_pend_add  <= 1'b0;
            r_pend_sub  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            case (r_key_state)
                K_IDLE: begin
                    if (bus.pressed) begin
                        r_key       <= bus.key;
                        r_key_state <= K_HELD;
                    end
                end
                K_HELD: begin
                    if (!bus.pressed)
                        r_key_state <= K_IDLE;
                end
                default: r_key_state <= K_IDLE;
            endcase
            r_value    <= w_next_value;
            r_pend_key <= w_next_pend_key;
            r_pend_add <= w_next_pend_add;
            r_pend_sub <= w_next_pend_sub;
            r_busy     <= w_next_pend_key | w_next_pend_add | w_next_pend_sub;
            r_drop     <= w_drop;
        end
    end

    assign bus.in0  = r_value[3:0];
    assign bus.in1  = r_value[7:4];
    assign bus.in2  = r_value[11:8];
    assign bus.in3  = r_value[15:12];
    assign bus.busy = r_busy;
    assign bus.drop = r_drop;

endmodule
`default_nettype wire
